// File: rtl/pwm_modulator.sv
// PWM DAC back end: rounds/saturates 16-bit samples to CNT_BITS duty, double-buffers them
// (pending -> active) so duty changes only on period boundaries, and drives a registered PWM pin.
module pwm_modulator #(
    parameter int CNT_BITS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] val,
    input  logic        val_valid,
    output logic        val_ready,
    output logic        pwm_out,
    output logic        period_start,
    output logic        underrun,
    output logic        busy
);

    localparam int SH = 16 - CNT_BITS;
    localparam logic [CNT_BITS-1:0] MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_BITS-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_BITS-1:0] r_duty_pend, r_duty_act, w_duty;
    logic                r_pend_valid;
    logic                r_pwm, r_ps, r_ur;
    logic                w_pwm_nxt, w_ps_nxt, w_ur_nxt;
    logic                w_load, w_accept, w_wrap;
    logic [16:0]         w_sum, w_d;

    // Round half-up to CNT_BITS, then clamp: a carry past MAX saturates instead of wrapping to 0.
    assign w_sum  = {1'b0, val} + (17'd1 << (SH - 1));
    assign w_d    = w_sum >> SH;
    assign w_duty = (w_d > {{(17-CNT_BITS){1'b0}}, MAX}) ? MAX : w_d[CNT_BITS-1:0];

    assign val_ready    = ~r_pend_valid;
    assign w_accept     = val_valid & ~r_pend_valid;
    assign w_wrap       = (r_cnt == MAX);
    assign busy         = (r_state != IDLE);
    assign pwm_out      = r_pwm;
    assign period_start = r_ps;
    assign underrun     = r_ur;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_pwm_nxt   = 1'b0;
        w_ps_nxt    = 1'b0;
        w_ur_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (en && r_pend_valid) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                    w_ps_nxt    = 1'b1;
                end
            end
            RUN: begin
                w_cnt_nxt = CNT_BITS'(r_cnt + 1'b1);
                w_pwm_nxt = (r_cnt < r_duty_act);
                if (w_wrap) begin
                    w_ps_nxt = 1'b1;
                    if (r_pend_valid) w_load   = 1'b1;
                    else              w_ur_nxt = 1'b1;
                end
                if (!en) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                w_cnt_nxt = CNT_BITS'(r_cnt + 1'b1);
                w_pwm_nxt = (r_cnt < r_duty_act);
                // Wrap wins over a late en: restart goes through IDLE so the load happens there.
                if (w_wrap)  w_state_nxt = IDLE;
                else if (en) w_state_nxt = RUN;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_pend_valid <= 1'b0;
            r_duty_pend  <= '0;
            r_duty_act   <= '0;
            r_pwm        <= 1'b0;
            r_ps         <= 1'b0;
            r_ur         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pwm   <= w_pwm_nxt;
            r_ps    <= w_ps_nxt;
            r_ur    <= w_ur_nxt;
            // Load needs a full buffer and accept an empty one, so they never coincide.
            if (w_load) begin
                r_duty_act   <= r_duty_pend;
                r_pend_valid <= 1'b0;
            end else if (w_accept) begin
                r_duty_pend  <= w_duty;
                r_pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_modulator.sv
// Directed bench for pwm_modulator at CNT_BITS=4 (period 16): rounding vectors, underrun,
// back-pressure, drain/restart and asynchronous reset mid-period.
module tb_pwm_modulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] val = '0;
    logic        val_valid = 1'b0;
    logic        val_ready, pwm_out, period_start, underrun, busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] v;
        int          d;
    } vec_t;

    vec_t vt[8];
    int   dseq[5];

    pwm_modulator #(.CNT_BITS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .val          (val),
        .val_valid    (val_valid),
        .val_ready    (val_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .underrun     (underrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en        = 1'b0;
        val_valid = 1'b0;
        val       = '0;
        rst_n     = 1'b0;
        #2;
        rst_n     = 1'b1;
        tick();
    endtask

    // Entered at a cnt==0 cycle; leaves at the next cnt==0 cycle.
    task automatic run_period(input int exp_duty, input bit bp, input int nd, input string tag);
        int hi, rdy, rdy0, patbad;
        logic [3:0] nd4;
        hi = 0; rdy = 0; rdy0 = 0; patbad = 0;
        nd4 = nd[3:0];
        for (int k = 0; k < 16; k++) begin
            if (val_ready) rdy++;
            if (k == 0) rdy0 = int'(val_ready);
            if (bp) begin
                val_valid = 1'b1;
                val = (k == 0) ? {nd4, 12'h000} : 16'($urandom);
            end
            tick();
            if (pwm_out) hi++;
            if (pwm_out !== (k < exp_duty)) patbad++;
        end
        chk($sformatf("%s high", tag), hi, exp_duty);
        chk($sformatf("%s pattern", tag), patbad, 0);
        if (bp) begin
            chk($sformatf("%s accepts", tag), rdy, 1);
            chk($sformatf("%s ready@cnt0", tag), rdy0, 1);
        end
    endtask

    initial begin
        int hi, patbad;
        vt[0] = '{16'h8000, 8};
        vt[1] = '{16'h07FF, 0};
        vt[2] = '{16'h0800, 1};
        vt[3] = '{16'hFFFF, 15};
        vt[4] = '{16'h4000, 4};
        vt[5] = '{16'h7FFF, 8};
        vt[6] = '{16'h17FF, 1};
        vt[7] = '{16'h1800, 2};
        dseq  = '{3, 11, 6, 14, 2};

        // reset state
        #12;
        chk("rst pwm", pwm_out, 0);
        chk("rst ps", period_start, 0);
        chk("rst ur", underrun, 0);
        chk("rst busy", busy, 0);
        chk("rst ready", val_ready, 1);
        rst_n = 1'b1;
        tick();

        // rounding/saturation vectors, each run for two periods (second one is an underrun reuse)
        for (int i = 0; i < 8; i++) begin
            do_reset();
            val = vt[i].v;
            val_valid = 1'b1;
            tick();
            val_valid = 1'b0;
            chk($sformatf("v%0d accept", i), val_ready, 0);
            chk($sformatf("v%0d idle busy", i), busy, 0);
            en = 1'b1;
            tick();
            chk($sformatf("v%0d start busy", i), busy, 1);
            chk($sformatf("v%0d start ps", i), period_start, 1);
            chk($sformatf("v%0d start ur", i), underrun, 0);
            run_period(vt[i].d, 1'b0, 0, $sformatf("v%0d p0", i));
            chk($sformatf("v%0d p1 ps", i), period_start, 1);
            chk($sformatf("v%0d p1 ur", i), underrun, 1);
            run_period(vt[i].d, 1'b0, 0, $sformatf("v%0d p1", i));
            chk($sformatf("v%0d p2 ur", i), underrun, 1);
            tick();
            chk($sformatf("v%0d ur 1cyc", i), underrun, 0);
            en = 1'b0;
        end

        // back-pressure: val_valid held high, val changes every cycle
        do_reset();
        val_valid = 1'b1;
        val = {4'd3, 12'h000};
        tick();
        chk("bp first accept", val_ready, 0);
        val = 16'h1234;
        tick();
        en = 1'b1;
        tick();
        chk("bp start ps", period_start, 1);
        for (int p = 0; p < 4; p++) begin
            run_period(dseq[p], 1'b1, dseq[p+1], $sformatf("bp p%0d", p));
            chk($sformatf("bp p%0d ur", p), underrun, 0);
            chk($sformatf("bp p%0d ps", p), period_start, 1);
        end
        val_valid = 1'b0;
        en = 1'b0;

        // en dropped at cnt==5: period completes, pending 16'h4000 kept for the restart
        do_reset();
        val = 16'h8000;
        val_valid = 1'b1;
        tick();
        en = 1'b1;
        val_valid = 1'b0;
        tick();
        hi = 0; patbad = 0;
        for (int k = 0; k < 16; k++) begin
            val_valid = (k == 0);
            val = 16'h4000;
            if (k == 5) en = 1'b0;
            tick();
            if (pwm_out) hi++;
            if (pwm_out !== (k < 8)) patbad++;
            if (k == 14) chk("drain busy", busy, 1);
        end
        val_valid = 1'b0;
        chk("drain high", hi, 8);
        chk("drain pattern", patbad, 0);
        chk("drain idle busy", busy, 0);
        chk("drain no ps", period_start, 0);
        chk("drain no ur", underrun, 0);
        tick(); tick(); tick();
        chk("idle pwm", pwm_out, 0);
        chk("idle busy", busy, 0);
        chk("idle pend kept", val_ready, 0);
        en = 1'b1;
        tick();
        chk("restart busy", busy, 1);
        chk("restart ps", period_start, 1);
        chk("restart load", val_ready, 1);
        run_period(4, 1'b0, 0, "restart");
        en = 1'b0;

        // asynchronous reset at cnt==7 with the output high and a sample pending
        do_reset();
        val = 16'h8000;
        val_valid = 1'b1;
        tick();
        val_valid = 1'b0;
        en = 1'b1;
        tick();
        val = 16'h4000;
        val_valid = 1'b1;
        tick();
        val_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("pre-rst pwm", pwm_out, 1);
        chk("pre-rst pend", val_ready, 0);
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst pwm", pwm_out, 0);
        chk("arst busy", busy, 0);
        chk("arst ready", val_ready, 1);
        chk("arst ps", period_start, 0);
        chk("arst ur", underrun, 0);
        #1;
        rst_n = 1'b1;
        en = 1'b1;
        tick(); tick(); tick();
        chk("post-rst discard busy", busy, 0);
        chk("post-rst ready", val_ready, 1);
        chk("post-rst pwm", pwm_out, 0);
        en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
